// File: rtl/byte_bank_memory.sv
// rtl/byte_bank_memory.sv - four byte-wide RAM banks with a write handshake FSM
//
// Purpose: unified instruction/data memory for the multi-cycle core. Reads
// return four consecutive bytes starting at any byte address (one cycle
// latency). Writes are byte/half/word requests with a done pulse and a sticky
// misalignment error.
//
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   address[31:0]   byte address for reads and writes (wraps above ADDR_W+2)
//   write[1:0]      00 none, 01 byte, 10 half, 11 word; held until done
//   d0..d3          write data, lane i goes to byte address+i
//   q0..q3          registered read data, lane i is byte address+i
//   done            one-cycle pulse when a write request completes
//   error           sticky misalignment flag of the last accepted write
//   busy            high while the write FSM is not idle
module byte_bank_memory #(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  input  logic [1:0]  write,
  input  logic [7:0]  d0,
  input  logic [7:0]  d1,
  input  logic [7:0]  d2,
  input  logic [7:0]  d3,
  output logic [7:0]  q0,
  output logic [7:0]  q1,
  output logic [7:0]  q2,
  output logic [7:0]  q3,
  output logic        done,
  output logic        error,
  output logic        busy
);

  localparam int AW = ADDR_W + 2;

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DONE, S_HOLD} state_t;

  state_t          state_q;
  logic [AW-1:0]   addr_q;
  logic [1:0]      size_q;
  logic [3:0][7:0] data_q;
  logic            aligned_q;
  logic            done_q;
  logic            error_q;
  logic            busy_q;
  logic [1:0]      off_q;
  logic [3:0][7:0] rd_bank;

  logic [AW-1:0]   addr_cur;
  logic            aligned_cur;
  logic [3:0]      lane_en;
  logic            unused_addr_hi;

  // Bytes beyond the storage size alias back onto it.
  assign addr_cur       = address[AW-1:0];
  assign unused_addr_hi = ^address[31:AW];

  always_comb begin
    aligned_cur = 1'b1;
    case (write)
      2'b10:   aligned_cur = ~addr_cur[0];
      2'b11:   aligned_cur = (addr_cur[1:0] == 2'b00);
      default: aligned_cur = 1'b1;
    endcase
  end

  always_comb begin
    lane_en = 4'b0000;
    case (size_q)
      2'b01:   lane_en = 4'b0001;
      2'b10:   lane_en = 4'b0011;
      2'b11:   lane_en = 4'b1111;
      default: lane_en = 4'b0000;
    endcase
  end

  // Write handshake FSM. done is registered, so it is seen the cycle after
  // DONE is entered, i.e. while the FSM sits in HOLD.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      size_q    <= 2'b00;
      data_q    <= '0;
      aligned_q <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (write != 2'b00) begin
            addr_q    <= addr_cur;
            size_q    <= write;
            data_q    <= {d3, d2, d1, d0};
            aligned_q <= aligned_cur;
            busy_q    <= 1'b1;
            state_q   <= S_WRITE;
          end
        end
        S_WRITE: begin
          error_q <= ~aligned_q;
          state_q <= S_DONE;
        end
        S_DONE: begin
          done_q  <= 1'b1;
          state_q <= S_HOLD;
        end
        S_HOLD: begin
          // Wait for the core to release the request so a held level
          // cannot retrigger a second commit.
          if (write == 2'b00) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      off_q <= 2'b00;
    end else begin
      off_q <= addr_cur[1:0];
    end
  end

  // Bank k serves whichever lane lands on it; that lane's byte address
  // decides the row, so a read crossing a word boundary picks row+1 for
  // the low banks.
  for (genvar k = 0; k < 4; k++) begin : g_bank
    logic [7:0]    mem [DEPTH_WORDS];
    logic [7:0]    rd_q;
    logic [1:0]    lane_rd;
    logic [AW-1:0] byte_rd;
    logic [1:0]    lane_wr;
    logic          we;

    assign lane_rd = 2'(k) - addr_cur[1:0];
    assign byte_rd = addr_cur + {{ADDR_W{1'b0}}, lane_rd};

    // Accepted writes are aligned, so every enabled lane shares one row.
    assign lane_wr = 2'(k) - addr_q[1:0];
    assign we      = rst && (state_q == S_WRITE) && aligned_q && lane_en[lane_wr];

    always_ff @(posedge clk) begin
      if (we) begin
        mem[addr_q[AW-1:2]] <= data_q[lane_wr];
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        rd_q <= 8'h00;
      end else begin
        rd_q <= mem[byte_rd[AW-1:2]];
      end
    end

    assign rd_bank[k] = rd_q;
  end

  assign q0    = rd_bank[off_q];
  assign q1    = rd_bank[off_q + 2'd1];
  assign q2    = rd_bank[off_q + 2'd2];
  assign q3    = rd_bank[off_q + 2'd3];
  assign done  = done_q;
  assign error = error_q;
  assign busy  = busy_q;

endmodule
